// File: rtl/rvsteel_bus_initiator_pkg.sv
// Shared definitions for RISC-V Steel I/O bus initiators: FSM encoding and
// response error codes.
package rvsteel_bus_initiator_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_t;

  localparam logic RspOk    = 1'b0;
  localparam logic RspError = 1'b1;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/rvsteel_bus_initiator.sv
// Single-outstanding initiator for the RISC-V Steel memory-mapped I/O bus.
// Commands arrive on a valid/ready port; responses or errors leave on another.
module rvsteel_bus_initiator
  import rvsteel_bus_initiator_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_strobe,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] rw_address,
  input  logic [31:0]           read_data,
  output logic                  read_request,
  input  logic                  read_response,
  output logic [31:0]           write_data,
  output logic [3:0]            write_strobe,
  output logic                  write_request,
  input  logic                  write_response
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_t                r_state, w_state;
  logic [CntW-1:0]       r_cnt, w_cnt;
  logic                  r_cmd_ready, w_cmd_ready;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [31:0]           r_rsp_rdata, w_rsp_rdata;
  logic                  r_rsp_error, w_rsp_error;
  logic                  r_rd_req, w_rd_req;
  logic                  r_wr_req, w_wr_req;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [31:0]           r_wdata, w_wdata;
  logic [3:0]            r_strobe, w_strobe;
  logic                  r_write, w_write;

  logic w_bus_rsp;
  logic w_timeout;

  // Only the response type matching the issued request completes it.
  assign w_bus_rsp = r_write ? write_response : read_response;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && ((32'(r_cnt) + 32'd1) == TIMEOUT_CYCLES);

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = r_rsp_rdata;
    w_rsp_error = r_rsp_error;
    w_rd_req    = 1'b0;
    w_wr_req    = 1'b0;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_strobe    = r_strobe;
    w_write     = r_write;
    unique case (r_state)
      StIdle: begin
        w_cmd_ready = 1'b1;
        if (r_cmd_ready && cmd_valid) begin
          w_cmd_ready = 1'b0;
          w_addr      = cmd_address;
          w_wdata     = cmd_wdata;
          w_strobe    = cmd_strobe;
          w_write     = cmd_write;
          if (!is_word_aligned(cmd_address[1:0])) begin
            w_state     = StResp;
            w_rsp_valid = 1'b1;
            w_rsp_error = RspError;
            w_rsp_rdata = 32'd0;
          end else begin
            w_state  = StWait;
            w_rd_req = !cmd_write;
            w_wr_req = cmd_write;
          end
        end
      end
      StWait: begin
        // A response in the same cycle as the timeout takes priority.
        if (w_bus_rsp) begin
          w_state     = StResp;
          w_rsp_valid = 1'b1;
          w_rsp_error = RspOk;
          w_rsp_rdata = r_write ? 32'd0 : read_data;
          w_cnt       = '0;
        end else if (w_timeout) begin
          w_state     = StResp;
          w_rsp_valid = 1'b1;
          w_rsp_error = RspError;
          w_rsp_rdata = 32'd0;
          w_cnt       = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      StResp: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state     = StIdle;
          w_rsp_valid = 1'b0;
          w_cmd_ready = 1'b1;
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_error <= 1'b0;
      r_rd_req    <= 1'b0;
      r_wr_req    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= 32'd0;
      r_strobe    <= 4'd0;
      r_write     <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_cmd_ready <= w_cmd_ready;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_error <= w_rsp_error;
      r_rd_req    <= w_rd_req;
      r_wr_req    <= w_wr_req;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_strobe    <= w_strobe;
      r_write     <= w_write;
    end
  end

  assign cmd_ready     = r_cmd_ready;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_error     = r_rsp_error;
  assign rw_address    = r_addr;
  assign write_data    = r_wdata;
  assign write_strobe  = r_strobe;
  assign read_request  = r_rd_req;
  assign write_request = r_wr_req;

endmodule

// File: tb/tb_rvsteel_bus_initiator.sv
// Bench for rvsteel_bus_initiator: registered memory-like responder, expected
// responses queued at issue and checked by an independent monitor.
module tb_rvsteel_bus_initiator;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_address, cmd_wdata;
  logic [3:0]  cmd_strobe;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] rw_address, read_data, write_data;
  logic        read_request, read_response, write_request, write_response;
  logic [3:0]  write_strobe;

  // Responder model state
  logic [31:0] mem [0:15];
  bit          mem_ready = 1'b0;
  logic        rd_resp_q = 1'b0, wr_resp_q = 1'b0;
  logic [31:0] rd_data_q = 32'd0;
  logic        mute = 1'b0, inj_rd = 1'b0;

  int   n_checks = 0, n_fail = 0;
  int   cyc = 0, acc_cyc = 0, req_cnt = 0;
  bit   busy = 1'b0, rsp_seen = 1'b0;
  exp_t q[$];

  rvsteel_bus_initiator #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_address    (cmd_address),
    .cmd_wdata      (cmd_wdata),
    .cmd_strobe     (cmd_strobe),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_error      (rsp_error),
    .rw_address     (rw_address),
    .read_data      (read_data),
    .read_request   (read_request),
    .read_response  (read_response),
    .write_data     (write_data),
    .write_strobe   (write_strobe),
    .write_request  (write_request),
    .write_response (write_response)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign read_data      = rd_data_q;
  assign read_response  = rd_resp_q | inj_rd;
  assign write_response = wr_resp_q;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[5]    <= 32'hDEAD_BEEF;
      mem_ready <= 1'b1;
    end else begin
      rd_resp_q <= read_request && !mute;
      wr_resp_q <= write_request && !mute;
      if (read_request) rd_data_q <= mem[rw_address[5:2]];
      if (write_request)
        for (int b = 0; b < 4; b++)
          if (write_strobe[b]) mem[rw_address[5:2]][8*b +: 8] <= write_data[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every response cycle against the head of the queue.
  always @(negedge clock) begin
    if (!reset) begin
      busy     = 1'b0;
      rsp_seen = 1'b0;
    end else begin
      if (busy) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        busy    = 1'b1;
      end
      if (read_request || write_request) req_cnt++;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          check("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
        end else begin
          if (!rsp_seen) begin
            rsp_seen = 1'b1;
            if (q[0].lat >= 0) check("rsp_latency", 32'(cyc - acc_cyc), 32'(q[0].lat));
          end
          check("rsp_rdata", rsp_rdata, q[0].rdata);
          check("rsp_error", 32'(rsp_error), 32'(q[0].err));
          if (rsp_ready) begin
            void'(q.pop_front());
            rsp_seen = 1'b0;
            busy     = 1'b0;
          end
        end
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit push, input logic [31:0] erd,
                       input logic eerr, input int elat);
    int n = 0;
    exp_t e;
    e.rdata = erd;
    e.err   = eerr;
    e.lat   = elat;
    if (push) q.push_back(e);
    cmd_write   = wr;
    cmd_address = addr;
    cmd_wdata   = wdata;
    cmd_strobe  = strb;
    cmd_valid   = 1'b1;
    @(negedge clock);
    while (!cmd_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!cmd_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_accept: cmd_ready=0, expected 1 within 50 cycles");
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: %0d responses outstanding, expected 0", q.size());
      q.delete();
    end
    @(posedge clock);
    #1;
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [31:0] erd, input logic eerr,
                     input int elat, input int ereq);
    int r0 = req_cnt;
    issue(wr, addr, wdata, strb, 1'b1, erd, eerr, elat);
    wait_idle();
    check("request_pulses", 32'(req_cnt - r0), 32'(ereq));
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_rsp_error", 32'(rsp_error), 32'd0);
    check("rst_requests", {30'd0, read_request, write_request}, 32'd0);
    check("rst_rw_address", rw_address, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_write_strobe", 32'(write_strobe), 32'd0);
  endtask

  initial begin
    int r0;
    int n;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_address = 32'd0;
    cmd_wdata   = 32'd0;
    cmd_strobe  = 4'd0;
    rsp_ready   = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock);
    #1 reset = 1'b1;

    // Reads/writes against the responder: latency 3, one request pulse each
    txn(1'b0, 32'h08, 32'd0,          4'hF, 32'h0000_0000, 1'b0, 3, 1);
    txn(1'b1, 32'h0C, 32'h0000_0010,  4'hF, 32'h0000_0000, 1'b0, 3, 1);
    txn(1'b0, 32'h0C, 32'd0,          4'hF, 32'h0000_0010, 1'b0, 3, 1);
    txn(1'b1, 32'h00, 32'h0000_0001,  4'hF, 32'h0000_0000, 1'b0, 3, 1);
    txn(1'b0, 32'h00, 32'd0,          4'hF, 32'h0000_0001, 1'b0, 3, 1);
    txn(1'b1, 32'h04, 32'hAABB_CCDD,  4'b0101, 32'h0,      1'b0, 3, 1);
    txn(1'b0, 32'h04, 32'd0,          4'hF, 32'h00BB_00DD, 1'b0, 3, 1);

    // Misaligned: no bus request, error one cycle after acceptance
    txn(1'b0, 32'h06, 32'd0, 4'hF, 32'h0, 1'b1, 1, 0);

    // Silent responder: 16 WAIT cycles then error
    mute = 1'b1;
    txn(1'b0, 32'h08, 32'd0, 4'hF, 32'h0, 1'b1, 17, 1);
    mute = 1'b0;

    // Response held: outputs stable, second command refused
    rsp_ready = 1'b0;
    r0 = req_cnt;
    issue(1'b0, 32'h14, 32'd0, 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clock);
    #1 cmd_valid = 1'b1;
    cmd_address = 32'h00;
    cmd_write   = 1'b0;
    repeat (5) begin
      @(negedge clock);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    @(posedge clock);
    #1 cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check("hold_request_pulses", 32'(req_cnt - r0), 32'd1);

    // Reset during WAIT, late response right after reset release
    mute = 1'b1;
    issue(1'b0, 32'h08, 32'd0, 4'hF, 1'b0, 32'h0, 1'b0, -1);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    inj_rd = 1'b1;
    @(negedge clock);
    check_reset_outputs();
    @(posedge clock);
    #1 inj_rd = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    mute = 1'b0;
    @(posedge clock);
    #1;
    txn(1'b0, 32'h00, 32'd0, 4'hF, 32'h0000_0001, 1'b0, 3, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
